// File: rtl/nx_mem_cmd_engine.sv
// nx_mem_cmd_engine: executes capability-checked indirect commands against one 1RW RAM
module nx_mem_cmd_engine #(
    parameter int          N_ENTRIES    = 1024,
    parameter int          DATA_W       = 32,
    parameter int          ADDR_W       = $clog2(N_ENTRIES),
    parameter logic [15:0] CAPABILITIES = 16'h03FF,
    parameter int          TMO_CYCLES   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W:0]   cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [2:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              enabled,
    output logic              init_busy
);
    localparam int TW = $clog2(TMO_CYCLES + 1);
    localparam logic [ADDR_W:0]   N_MAX  = (ADDR_W + 1)'(N_ENTRIES);
    localparam logic [ADDR_W-1:0] A_PEN  = ADDR_W'(N_ENTRIES - 2);
    localparam logic [TW-1:0]     T_LAST = TW'(TMO_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, MEM_RD, RD_CAP, SWEEP, TMO, RSP} state_t;
    state_t state, state_n;
    logic [3:0] op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W:0] init_start, init_start_n;
    logic [TW-1:0] cnt, cnt_n;
    logic cmd_ready_n, rsp_valid_n, mem_cs_n, mem_we_n, enabled_n, init_busy_n;
    logic [2:0] rsp_status_n;
    logic [DATA_W-1:0] rsp_rdata_n, mem_wdata_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic accept, unsup, dis, aerr, err, is_rd, is_init, init_last;
    logic [2:0] err_status;
    assign accept     = cmd_valid & cmd_ready;
    assign is_rd      = cmd_op inside {4'd1, 4'd9};
    assign is_init    = cmd_op inside {4'd6, 4'd7};
    assign init_last  = init_start == N_MAX - 1'b1;
    assign unsup      = !CAPABILITIES[cmd_op] || (cmd_op inside {[4'd10:4'd13]});
    assign dis        = !enabled && (cmd_op inside {4'd1, 4'd2, 4'd6, 4'd7, 4'd9});
    assign aerr       = ((cmd_op inside {4'd1, 4'd2, 4'd8, 4'd9}) && cmd_addr >= N_MAX) || (is_init && init_start >= N_MAX);
    assign err        = unsup | dis | aerr;
    assign err_status = unsup ? 3'd1 : dis ? 3'd2 : aerr ? 3'd3 : 3'd0;
    // state, captured command fields and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= '0;
            wdata_q    <= '0;
            init_start <= '0;
            cnt        <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
            rsp_rdata  <= '0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            enabled    <= 1'b1;
            init_busy  <= 1'b0;
        end else begin
            state      <= state_n;
            op_q       <= accept ? cmd_op : op_q;
            wdata_q    <= accept ? cmd_wdata : wdata_q;
            init_start <= init_start_n;
            cnt        <= cnt_n;
            cmd_ready  <= cmd_ready_n;
            rsp_valid  <= rsp_valid_n;
            rsp_status <= rsp_status_n;
            rsp_rdata  <= rsp_rdata_n;
            mem_cs     <= mem_cs_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            enabled    <= enabled_n;
            init_busy  <= init_busy_n;
        end
    end
    // next state: every path into RSP is the cycle the response becomes visible
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = err ? RSP : is_rd ? MEM_RD : is_init ? (init_last ? RSP : SWEEP) : (cmd_op == 4'd14 && TMO_CYCLES > 1) ? TMO : RSP;
            MEM_RD:  state_n = RD_CAP;
            RD_CAP:  state_n = RSP;
            SWEEP:   state_n = mem_addr == A_PEN ? RSP : SWEEP;
            TMO:     state_n = cnt == T_LAST ? RSP : TMO;
            default: state_n = IDLE;
        endcase
    end
    // next values of the registered outputs and control registers
    always_comb begin
        cmd_ready_n  = state_n == IDLE;
        rsp_valid_n  = state_n == RSP;
        rsp_status_n = rsp_status;
        rsp_rdata_n  = '0;
        mem_cs_n     = 1'b0;
        mem_we_n     = 1'b0;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        enabled_n    = enabled;
        init_start_n = init_start;
        init_busy_n  = 1'b0;
        cnt_n        = cnt + 1'b1;
        case (state)
            IDLE: if (accept) begin
                rsp_status_n = err ? err_status : cmd_op == 4'd14 ? 3'd5 : cmd_op == 4'd15 ? 3'd6 : 3'd0;
                enabled_n    = err ? enabled : cmd_op inside {4'd3, 4'd5} ? 1'b1 : cmd_op == 4'd4 ? 1'b0 : enabled;
                init_start_n = err ? init_start : cmd_op == 4'd5 ? '0 : cmd_op == 4'd8 ? cmd_addr : init_start;
                mem_cs_n     = !err && (is_rd || is_init || cmd_op == 4'd2);
                mem_we_n     = !err && (is_init || cmd_op == 4'd2);
                mem_addr_n   = is_init ? init_start[ADDR_W-1:0] : cmd_addr[ADDR_W-1:0];
                mem_wdata_n  = cmd_wdata;
                init_busy_n  = !err && is_init;
                cnt_n        = TW'(1);
            end
            SWEEP: begin
                mem_cs_n    = 1'b1;
                mem_we_n    = 1'b1;
                mem_addr_n  = mem_addr + 1'b1;
                mem_wdata_n = mem_wdata + DATA_W'(op_q == 4'd7);
                init_busy_n = 1'b1;
            end
            RD_CAP: begin
                rsp_rdata_n  = mem_rdata;
                rsp_status_n = (op_q == 4'd9 && mem_rdata != wdata_q) ? 3'd4 : 3'd0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_nx_mem_cmd_engine.sv
// tb_nx_mem_cmd_engine: table-driven and directed checks of the memory command engine
module tb_nx_mem_cmd_engine;
    localparam int N = 1024, DW = 32, AW = 10;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic cmd_valid = 0, cmd_ready, rsp_valid, mem_cs, mem_we, enabled, init_busy;
    logic [3:0] cmd_op = 0;
    logic [AW:0] cmd_addr = 0;
    logic [DW-1:0] cmd_wdata = 0, rsp_rdata, mem_wdata, mem_rdata;
    logic [2:0] rsp_status;
    logic [AW-1:0] mem_addr;
    logic nc_valid = 0, nc_ready, nc_rsp_valid, nc_cs, nc_we, nc_en, nc_busy;
    logic [3:0] nc_op = 0;
    logic [2:0] nc_status;
    logic [DW-1:0] nc_rdata, nc_wdata;
    logic [AW-1:0] nc_addr;
    logic [DW-1:0] ram [N];

    nx_mem_cmd_engine #(.N_ENTRIES(N), .DATA_W(DW), .CAPABILITIES(16'hC3FF), .TMO_CYCLES(64)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .rsp_rdata(rsp_rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .enabled(enabled), .init_busy(init_busy));

    nx_mem_cmd_engine #(.N_ENTRIES(N), .DATA_W(DW), .CAPABILITIES(16'h01FF), .TMO_CYCLES(64)) u_nc (
        .clk(clk), .rst(rst), .cmd_valid(nc_valid), .cmd_ready(nc_ready), .cmd_op(nc_op),
        .cmd_addr(11'd5), .cmd_wdata(32'd0), .rsp_valid(nc_rsp_valid), .rsp_status(nc_status),
        .rsp_rdata(nc_rdata), .mem_cs(nc_cs), .mem_we(nc_we), .mem_addr(nc_addr),
        .mem_wdata(nc_wdata), .mem_rdata(32'd0), .enabled(nc_en), .init_busy(nc_busy));

    always @(posedge clk) if (mem_cs) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else mem_rdata <= ram[mem_addr];
    end

    int errs = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [AW:0] a, input logic [DW-1:0] d);
        chk("ready_before_issue", cmd_ready, 1);
        @(negedge clk);
        cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1;
        @(posedge clk);
        #1;
        cmd_valid = 0; cmd_op = 4'd2; cmd_addr = 11'd7; cmd_wdata = ~d;
    endtask

    typedef struct {
        logic [3:0] op; logic [AW:0] addr; logic [DW-1:0] wd;
        int lat; logic [2:0] st; logic [DW-1:0] rd; logic cs; logic en;
    } vec_t;
    vec_t v [19];

    initial begin
        int k;
        logic [DW-1:0] e;
        v = '{
            '{4'd2,  11'd5,    32'hA5A5_0001, 1,  3'd0, 32'h0,         1'b1, 1'b1},
            '{4'd1,  11'd5,    32'h0,         3,  3'd0, 32'hA5A5_0001, 1'b1, 1'b1},
            '{4'd9,  11'd5,    32'hA5A5_0002, 3,  3'd4, 32'hA5A5_0001, 1'b1, 1'b1},
            '{4'd9,  11'd5,    32'hA5A5_0001, 3,  3'd0, 32'hA5A5_0001, 1'b1, 1'b1},
            '{4'd4,  11'd0,    32'h0,         1,  3'd0, 32'h0,         1'b0, 1'b0},
            '{4'd2,  11'd3,    32'h33,        1,  3'd2, 32'h0,         1'b0, 1'b0},
            '{4'd1,  11'd3,    32'h0,         1,  3'd2, 32'h0,         1'b0, 1'b0},
            '{4'd3,  11'd0,    32'h0,         1,  3'd0, 32'h0,         1'b0, 1'b1},
            '{4'd2,  11'd3,    32'h33,        1,  3'd0, 32'h0,         1'b1, 1'b1},
            '{4'd1,  11'd3,    32'h0,         3,  3'd0, 32'h33,        1'b1, 1'b1},
            '{4'd1,  11'd1024, 32'h0,         1,  3'd3, 32'h0,         1'b0, 1'b1},
            '{4'd2,  11'd2047, 32'h1,         1,  3'd3, 32'h0,         1'b0, 1'b1},
            '{4'd11, 11'd0,    32'h0,         1,  3'd1, 32'h0,         1'b0, 1'b1},
            '{4'd13, 11'd0,    32'h0,         1,  3'd1, 32'h0,         1'b0, 1'b1},
            '{4'd0,  11'd0,    32'h0,         1,  3'd0, 32'h0,         1'b0, 1'b1},
            '{4'd15, 11'd0,    32'h0,         1,  3'd6, 32'h0,         1'b0, 1'b1},
            '{4'd14, 11'd0,    32'h0,         64, 3'd5, 32'h0,         1'b0, 1'b1},
            '{4'd8,  11'd1024, 32'h0,         1,  3'd3, 32'h0,         1'b0, 1'b1},
            '{4'd8,  11'd1020, 32'h0,         1,  3'd0, 32'h0,         1'b0, 1'b1}
        };
        repeat (3) step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_enabled", enabled, 1);
        chk("rst_busy", init_busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cs", mem_cs, 0);
        rst = 0;
        step();
        for (int i = 0; i < 19; i++) begin
            issue(v[i].op, v[i].addr, v[i].wd);
            chk($sformatf("v%0d_cs", i), mem_cs, v[i].cs);
            chk($sformatf("v%0d_en", i), enabled, v[i].en);
            k = 1;
            while (!rsp_valid && k < 300) begin step(); k++; end
            chk($sformatf("v%0d_latency", i), k, v[i].lat);
            chk($sformatf("v%0d_status", i), rsp_status, v[i].st);
            chk($sformatf("v%0d_rdata", i), rsp_rdata, v[i].rd);
            chk($sformatf("v%0d_ready_at_rsp", i), cmd_ready, 0);
            step();
            chk($sformatf("v%0d_ready_after", i), cmd_ready, 1);
            chk($sformatf("v%0d_pulse", i), rsp_valid, 0);
        end
        // INIT_INC from 1020 wraps the data past 2^32
        issue(4'd7, 11'd0, 32'hFFFF_FFFE);
        for (int j = 1; j <= 4; j++) begin
            e = 32'hFFFF_FFFE + DW'(j - 1);
            chk($sformatf("inc%0d_cs", j), {mem_cs, mem_we}, 2'b11);
            chk($sformatf("inc%0d_addr", j), mem_addr, 1019 + j);
            chk($sformatf("inc%0d_data", j), mem_wdata, e);
            chk($sformatf("inc%0d_busy", j), init_busy, 1);
            chk($sformatf("inc%0d_rsp", j), rsp_valid, j == 4);
            step();
        end
        chk("inc_done_busy", init_busy, 0);
        chk("inc_done_cs", mem_cs, 0);
        chk("inc_done_ready", cmd_ready, 1);
        // capability gating on an instance without COMPARE/SIM_TMO
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            nc_op = j == 0 ? 4'd9 : 4'd14; nc_valid = 1;
            @(posedge clk);
            #1 nc_valid = 0;
            chk($sformatf("nc%0d_rsp", j), nc_rsp_valid, 1);
            chk($sformatf("nc%0d_status", j), nc_status, 1);
            chk($sformatf("nc%0d_cs", j), nc_cs, 0);
            step();
        end
        // RESET op then abort a full INIT at strobe 10
        issue(4'd5, 11'd0, 32'h0);
        chk("reset_op_rsp", {rsp_valid, rsp_status}, 4'b1000);
        step();
        issue(4'd6, 11'd0, 32'h77);
        chk("init_first_addr", mem_addr, 0);
        repeat (9) step();
        chk("init_strobe10", {mem_cs, mem_we, init_busy, rsp_valid}, 4'b1110);
        chk("init_strobe10_addr", mem_addr, 9);
        rst = 1;
        step();
        rst = 0;
        chk("abort_ready", cmd_ready, 1);
        chk("abort_enabled", enabled, 1);
        chk("abort_busy", init_busy, 0);
        chk("abort_cs_rsp", {mem_cs, rsp_valid}, 2'b00);
        step();
        chk("abort_no_rsp", rsp_valid, 0);
        issue(4'd8, 11'd1020, 32'h0);
        chk("set_start_rsp", {rsp_valid, rsp_status}, 4'b1000);
        step();
        rst = 1;
        step();
        rst = 0;
        step();
        issue(4'd6, 11'd0, 32'h5A);
        chk("reinit_first_addr", mem_addr, 0);
        chk("reinit_first_data", mem_wdata, 32'h5A);
        k = 1;
        while (!rsp_valid && k < 2000) begin step(); k++; end
        chk("reinit_latency", k, 1024);
        chk("reinit_last_addr", mem_addr, 1023);
        chk("reinit_last_strobe", {mem_cs, mem_we, init_busy}, 3'b111);
        chk("reinit_status", rsp_status, 0);
        step();
        chk("reinit_done", {cmd_ready, init_busy, mem_cs}, 3'b100);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
